// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared types and defaults for the APB master bridge
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_AW      = 9;
  localparam int APB_DW      = 8;
  localparam int APB_TIMEOUT = 16;

  // Address MSB picks between the two slaves
  localparam int APB_SEL_BIT = APB_AW - 1;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - saturating ACCESS wait-state counter
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Holds at LIMIT so a stalled slave can never wrap the count back to zero
  always_ff @(posedge i_clk) begin
    if (!i_resetn || i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - APB3 master: request latch, SETUP/ACCESS sequencing, timeout abort
module apb_master_bridge
  import apb_bridge_pkg::*;
#(
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          transfer,
  input  logic          READ_WRITE,
  input  logic [AW-1:0] apb_read_paddr,
  input  logic [AW-1:0] apb_write_paddr,
  input  logic [DW-1:0] apb_write_data,
  output logic [DW-1:0] apb_read_data_out,
  output logic          xfer_done,
  output logic          xfer_err,
  output logic          PSEL1,
  output logic          PSEL2,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  localparam int SEL_BIT = APB_SEL_BIT + (AW - APB_AW);

  apb_state_e    r_state;
  logic          r_pwrite;
  logic [AW-1:0] r_paddr;
  logic [DW-1:0] r_pwdata;
  logic [DW-1:0] r_rdata;
  logic          r_done;
  logic          r_err;

  logic w_access;
  logic w_setup;
  logic w_complete;
  logic w_abort;
  logic w_latch;
  logic w_wait;
  logic w_expired;

  assign w_access   = (r_state == ACCESS);
  assign w_setup    = (r_state == SETUP);
  assign w_complete = w_access && PREADY;
  assign w_wait     = w_access && !PREADY;
  assign w_abort    = w_wait && w_expired;
  // New requests are accepted only from IDLE or on the completing ACCESS edge
  assign w_latch    = transfer && ((r_state == IDLE) || w_complete);

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .i_clk     (PCLK),
    .i_resetn  (PRESETn),
    .i_clear   (w_setup),
    .i_inc     (w_wait),
    .o_expired (w_expired)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (transfer) r_state <= SETUP;
        SETUP:   r_state <= ACCESS;
        ACCESS: begin
          if (w_complete) begin
            r_state <= transfer ? SETUP : IDLE;
          end else if (w_abort) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_rdata  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_complete || w_abort;
      r_err  <= (w_complete && PSLVERR) || w_abort;
      if (w_complete && !r_pwrite && !PSLVERR) begin
        r_rdata <= PRDATA;
      end
      // PWDATA is left alone on reads so the bus keeps the last write value
      if (w_latch) begin
        r_pwrite <= READ_WRITE;
        r_paddr  <= READ_WRITE ? apb_write_paddr : apb_read_paddr;
        if (READ_WRITE) begin
          r_pwdata <= apb_write_data;
        end
      end
    end
  end

  assign PSEL1             = (r_state != IDLE) && !r_paddr[SEL_BIT];
  assign PSEL2             = (r_state != IDLE) &&  r_paddr[SEL_BIT];
  assign PENABLE           = w_access;
  assign PWRITE            = r_pwrite;
  assign PADDR             = r_paddr;
  assign PWDATA            = r_pwdata;
  assign apb_read_data_out = r_rdata;
  assign xfer_done         = r_done;
  assign xfer_err          = r_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - scoreboard bench for apb_master_bridge
module tb_apb_master_bridge;

  logic       PCLK;
  logic       PRESETn;
  logic       transfer;
  logic       READ_WRITE;
  logic [8:0] apb_read_paddr;
  logic [8:0] apb_write_paddr;
  logic [7:0] apb_write_data;
  logic [7:0] apb_read_data_out;
  logic       xfer_done;
  logic       xfer_err;
  logic       PSEL1;
  logic       PSEL2;
  logic       PENABLE;
  logic       PWRITE;
  logic [8:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  apb_master_bridge #(
    .AW      (9),
    .DW      (8),
    .TIMEOUT (16)
  ) dut (
    .PCLK              (PCLK),
    .PRESETn           (PRESETn),
    .transfer          (transfer),
    .READ_WRITE        (READ_WRITE),
    .apb_read_paddr    (apb_read_paddr),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_data_out (apb_read_data_out),
    .xfer_done         (xfer_done),
    .xfer_err          (xfer_err),
    .PSEL1             (PSEL1),
    .PSEL2             (PSEL2),
    .PENABLE           (PENABLE),
    .PWRITE            (PWRITE),
    .PADDR             (PADDR),
    .PWDATA            (PWDATA),
    .PRDATA            (PRDATA),
    .PREADY            (PREADY),
    .PSLVERR           (PSLVERR)
  );

  typedef struct {
    logic       sel2;
    logic       wr;
    logic [8:0] addr;
    logic [7:0] wdata;
  } setup_t;

  typedef struct {
    logic       err;
    logic [7:0] rd;
    int         acc;
    int         gap;
  } done_t;

  typedef struct {
    int         waits;
    logic [7:0] prd;
    logic       perr;
  } slv_t;

  setup_t setup_q[$];
  done_t  done_q[$];
  slv_t   slave_q[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    forever begin
      @(posedge PCLK);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model: per-transfer wait count, read data and error taken from slave_q
  initial begin
    slv_t cur;
    int   scnt;
    cur     = '{waits: 0, prd: 8'h00, perr: 1'b0};
    scnt    = 0;
    PREADY  = 1'b0;
    PRDATA  = 8'h00;
    PSLVERR = 1'b0;
    forever begin
      @(negedge PCLK);
      if (PRESETn && (PSEL1 || PSEL2) && !PENABLE && (slave_q.size() > 0)) begin
        cur  = slave_q.pop_front();
        scnt = 0;
      end
      if (PENABLE) begin
        scnt++;
        PREADY = (scnt > cur.waits);
      end else begin
        scnt   = 0;
        PREADY = 1'b0;
      end
      PRDATA  = cur.prd;
      PSLVERR = cur.perr && PREADY;
    end
  end

  // Monitor: compares bus phases and completions against the queues
  initial begin
    setup_t     s;
    done_t      d;
    int         acc;
    int         last_done;
    logic [7:0] hold;
    logic       prev_setup;
    logic [1:0] prev_sel;
    acc        = 0;
    last_done  = 0;
    hold       = 8'h00;
    prev_setup = 1'b0;
    prev_sel   = 2'b00;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        acc        = 0;
        hold       = 8'h00;
        prev_setup = 1'b0;
      end else begin
        if (xfer_done) begin
          if (done_q.size() == 0) begin
            check("unexpected_done", 32'(xfer_done), 32'd0);
          end else begin
            d = done_q.pop_front();
            check("xfer_err", 32'(xfer_err), 32'(d.err));
            check("rdata_out", 32'(apb_read_data_out), 32'(d.rd));
            check("access_len", acc, d.acc);
            if (d.gap > 0) check("done_gap", cyc - last_done, d.gap);
            hold = d.rd;
          end
          last_done = cyc;
        end else if (xfer_err) begin
          check("err_without_done", 32'(xfer_err), 32'd0);
        end
        if (prev_setup) begin
          check("penable_after_setup", 32'(PENABLE), 32'd1);
          check("psel_held", 32'({PSEL2, PSEL1}), 32'(prev_sel));
        end
        prev_setup = 1'b0;
        if ((PSEL1 || PSEL2) && !PENABLE) begin
          if (setup_q.size() == 0) begin
            check("unexpected_setup", 32'(PSEL1 | PSEL2), 32'd0);
          end else begin
            s        = setup_q.pop_front();
            prev_sel = s.sel2 ? 2'b10 : 2'b01;
            check("setup_psel", 32'({PSEL2, PSEL1}), 32'(prev_sel));
            check("setup_pwrite", 32'(PWRITE), 32'(s.wr));
            check("setup_paddr", 32'(PADDR), 32'(s.addr));
            check("setup_pwdata", 32'(PWDATA), 32'(s.wdata));
          end
          prev_setup = 1'b1;
          acc        = 0;
        end
        if (PENABLE) begin
          acc++;
          check("rdata_held", 32'(apb_read_data_out), 32'(hold));
        end
      end
    end
  end

  task automatic expect_xfer(input logic wr, input logic [8:0] addr, input logic [7:0] pwd,
                             input int waits, input logic [7:0] prd, input logic perr,
                             input logic eerr, input logic [7:0] erd, input int eacc,
                             input int gap, input bit has_done);
    setup_q.push_back('{sel2: addr[8], wr: wr, addr: addr, wdata: pwd});
    slave_q.push_back('{waits: waits, prd: prd, perr: perr});
    if (has_done) done_q.push_back('{err: eerr, rd: erd, acc: eacc, gap: gap});
  endtask

  // Unused address/data inputs carry junk so a wrong mux choice is visible
  task automatic set_req(input logic wr, input logic [8:0] addr, input logic [7:0] wdata);
    READ_WRITE = wr;
    if (wr) begin
      apb_write_paddr = addr;
      apb_write_data  = wdata;
      apb_read_paddr  = 9'h0EE;
    end else begin
      apb_read_paddr  = addr;
      apb_write_paddr = 9'h0EE;
      apb_write_data  = 8'hEE;
    end
  endtask

  task automatic drive(input logic wr, input logic [8:0] addr, input logic [7:0] wdata);
    set_req(wr, addr, wdata);
    transfer = 1'b1;
    @(posedge PCLK);
    #1;
    transfer = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((done_q.size() != 0) && (n < budget)) begin
      @(posedge PCLK);
      #2;
      n++;
    end
    if (done_q.size() != 0) begin
      check("completion_timeout", done_q.size(), 0);
      done_q.delete();
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_psel_penable", 32'({PSEL1, PSEL2, PENABLE}), 32'd0);
    check("rst_pwrite", 32'(PWRITE), 32'd0);
    check("rst_paddr", 32'(PADDR), 32'd0);
    check("rst_pwdata", 32'(PWDATA), 32'd0);
    check("rst_rdata_out", 32'(apb_read_data_out), 32'd0);
    check("rst_done_err", 32'({xfer_done, xfer_err}), 32'd0);
  endtask

  initial begin
    PRESETn         = 1'b0;
    transfer        = 1'b0;
    READ_WRITE      = 1'b0;
    apb_read_paddr  = 9'h000;
    apb_write_paddr = 9'h000;
    apb_write_data  = 8'h00;
    repeat (3) @(posedge PCLK);
    #1;
    check_reset_outputs();
    PRESETn = 1'b1;

    // write, slave 1, zero wait; PRDATA must not be captured on a write
    expect_xfer(1'b1, 9'h005, 8'hA5, 0, 8'hDD, 1'b0, 1'b0, 8'h00, 1, 0, 1'b1);
    drive(1'b1, 9'h005, 8'hA5);
    wait_idle(50);

    // read, slave 2, three waits
    expect_xfer(1'b0, 9'h10C, 8'hA5, 3, 8'h3C, 1'b0, 1'b0, 8'h3C, 4, 0, 1'b1);
    drive(1'b0, 9'h10C, 8'h00);
    wait_idle(50);

    // back-to-back write 0x0FF then read 0x1FF with transfer held high
    expect_xfer(1'b1, 9'h0FF, 8'h5A, 0, 8'h11, 1'b0, 1'b0, 8'h3C, 1, 0, 1'b1);
    expect_xfer(1'b0, 9'h1FF, 8'h5A, 0, 8'hC3, 1'b0, 1'b0, 8'hC3, 1, 2, 1'b1);
    set_req(1'b1, 9'h0FF, 8'h5A);
    transfer = 1'b1;
    @(posedge PCLK);
    #1;
    set_req(1'b0, 9'h1FF, 8'h00);
    repeat (2) @(posedge PCLK);
    #1;
    transfer = 1'b0;
    wait_idle(50);

    // slave error on read keeps previous read data
    expect_xfer(1'b0, 9'h020, 8'h5A, 1, 8'h77, 1'b1, 1'b1, 8'hC3, 2, 0, 1'b1);
    drive(1'b0, 9'h020, 8'h00);
    wait_idle(50);

    // PREADY never rises: abort after 16 ACCESS cycles
    expect_xfer(1'b0, 9'h100, 8'h5A, 1000, 8'h44, 1'b0, 1'b1, 8'hC3, 16, 0, 1'b1);
    drive(1'b0, 9'h100, 8'h00);
    wait_idle(60);
    check("idle_after_timeout", 32'({PSEL1, PSEL2, PENABLE}), 32'd0);

    // reset during ACCESS: no completion, everything back to zero
    expect_xfer(1'b1, 9'h033, 8'h11, 1000, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0, 1'b0);
    drive(1'b1, 9'h033, 8'h11);
    repeat (2) @(posedge PCLK);
    #1;
    check("access_before_reset", 32'(PENABLE), 32'd1);
    PRESETn = 1'b0;
    @(posedge PCLK);
    #1;
    check_reset_outputs();
    PRESETn = 1'b1;

    expect_xfer(1'b1, 9'h1AA, 8'h22, 0, 8'h00, 1'b0, 1'b0, 8'h00, 1, 0, 1'b1);
    drive(1'b1, 9'h1AA, 8'h22);
    wait_idle(50);

    expect_xfer(1'b0, 9'h0AA, 8'h22, 2, 8'h99, 1'b0, 1'b0, 8'h99, 3, 0, 1'b1);
    drive(1'b0, 9'h0AA, 8'h00);
    wait_idle(50);

    repeat (3) @(posedge PCLK);
    #1;
    check("setups_consumed", setup_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

RTL APB master bridge that consumes the testbench-driven master controls (`transfer`, `READ_WRITE`, read/write addresses, write data) and runs APB3 SETUP/ACCESS cycles toward the two APB slaves. It sits directly downstream of the master control interface and upstream of the slave pair. The bridge decodes address MSB into one of two slave selects, returns read data on `apb_read_data_out`, and bounds wait states with a timeout counter.

## Interface
- `AW`, 9: address width; bit `AW-1` selects the slave.
- `DW`, 8: data width.
- `TIMEOUT`, 16: maximum ACCESS cycles with PREADY low before abort (≥2).
- `PCLK` in 1: single clock, rising edge.
- `PRESETn` in 1: reset, synchronous, active-low.
- `transfer` in 1: request; sampled in IDLE and at ACCESS completion.
- `READ_WRITE` in 1: 1 = write, 0 = read.
- `apb_read_paddr` in AW: read address.
- `apb_write_paddr` in AW: write address.
- `apb_write_data` in DW: write data.
- `apb_read_data_out` out DW: last successfully read data, held between reads.
- `xfer_done` out 1: one-cycle pulse per completed transfer, including errored or timed-out ones.
- `xfer_err` out 1: one-cycle pulse, coincident with `xfer_done`, on PSLVERR or timeout.
- `PSEL1` out 1: slave 1 select (`PADDR[AW-1]==0`).
- `PSEL2` out 1: slave 2 select (`PADDR[AW-1]==1`).
- `PENABLE` out 1: ACCESS phase.
- `PWRITE` out 1: direction.
- `PADDR` out AW: bus address.
- `PWDATA` out DW: write data.
- `PRDATA` in DW: muxed slave read data.
- `PREADY` in 1: slave ready.
- `PSLVERR` in 1: slave error.

## Operation
- FSM states are IDLE, SETUP and ACCESS.
- **IDLE:** PSELx=0, PENABLE=0. If `transfer`=1 at the edge:
  - latch `READ_WRITE` into PWRITE;
  - latch PADDR from `apb_write_paddr` if writing, else `apb_read_paddr`;
  - latch PWDATA from `apb_write_data`, writes only;
  - go to SETUP.
- **SETUP:**
  - Exactly one PSELx=1 per `PADDR[AW-1]`; PENABLE=0.
  - Unconditionally go to ACCESS; clear the timeout counter.
- **ACCESS:** selected PSELx=1, PENABLE=1.
  - If PREADY=1, the transfer completes:
    - On a read with PSLVERR=0, capture PRDATA into `apb_read_data_out`.
    - Pulse `xfer_done`; pulse `xfer_err` if PSLVERR=1.
    - If `transfer`=1, latch a new request and go to SETUP (back-to-back). Otherwise go to IDLE.
  - If PREADY=0, increment the counter. At count `TIMEOUT-1` with PREADY still 0: abort to IDLE, pulse `xfer_done` and `xfer_err`, leave `apb_read_data_out` unchanged.
- PADDR, PWRITE and PWDATA are registered. They change only on a request latch and are stable from SETUP through the end of ACCESS.
- PWDATA keeps its old value on reads.
- Controls changing during SETUP/ACCESS are ignored until completion.
- Timeout counter width is `$clog2(TIMEOUT)`; it saturates and never wraps.

## Timing
- **Reset:** when `PRESETn`=0 at a rising edge, the next cycle has state IDLE and all outputs 0: PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, `apb_read_data_out`, `xfer_done`, `xfer_err`. The counter is also 0.
- **Reset mid-transfer:** abandons the transfer with no `xfer_done`. There is no asynchronous path.
- **Request latency:** with `transfer` sampled at edge N in IDLE:
  - SETUP in cycle N+1;
  - ACCESS in cycle N+2;
  - with PREADY=1 at edge N+2, `apb_read_data_out` and `xfer_done` are valid in cycle N+3.
- **Throughput:** minimum 2 cycles per transfer. Back-to-back transfers re-enter SETUP and never skip it.
- PSELx, PENABLE and `xfer_*` are decoded from registered state or registered pulses, with no combinational path from inputs.

## Structure
- Package `apb_bridge_pkg` holds:
  - state enum `apb_state_e` {IDLE, SETUP, ACCESS};
  - default `AW`/`DW`/`TIMEOUT` constants;
  - slave-select bit index constant.
- Sub-module `apb_wait_timer` holds the clear/increment/expire counter with parameter `TIMEOUT`. The FSM and datapath stay in the top.

## Test plan
- **Write, zero wait:** `transfer`=1, `READ_WRITE`=1, waddr=0x005, wdata=0xA5, PREADY=1 → PSEL1 in SETUP, PENABLE next cycle, PADDR=0x005, PWDATA=0xA5, one `xfer_done`, no `xfer_err`.
- **Read, slave 2, 3 waits:** raddr=0x10C, PRDATA=0x3C, PREADY low 3 ACCESS cycles → PSEL2 only; `apb_read_data_out`=0x3C only after the PREADY edge; ACCESS lasts 4 cycles.
- **Back-to-back:** write 0x0FF then read 0x1FF with `transfer` held high → SETUP re-entered, PSEL switches PSEL1→PSEL2, two `xfer_done` pulses 2 cycles apart.
- **Error and timeout:**
  - PSLVERR=1 on a read → `xfer_err`+`xfer_done` pulse and `apb_read_data_out` keeps its previous value.
  - PREADY held 0 → abort after 16 ACCESS cycles with `xfer_err`, then IDLE.
- **Reset mid-ACCESS:** `PRESETn`=0 for one edge during ACCESS → all outputs 0 next cycle with no `xfer_done`; a subsequent transfer completes normally.
